mem_block_mover: RTL and testbench
==================================

# mem_block_mover

Bus-master engine that drives the single-port data memory interface (one shared address, combinational read, write on the clock edge) to perform block copy and block fill operations without processor involvement. It sits between the control path and the data memory, muxed onto the memory port while Busy is high. Copy takes two cycles per byte, one read then one write. Fill takes one cycle per byte.

## Interface
- W, 8, data width; matches the memory entry width
- A, 8, address width; the memory is 2**A entries deep
- Clk  input  1  clock; all state changes on posedge
- Reset  input  1  synchronous, active-high; overrides every other input
- Start  input  1  request; sampled only in IDLE
- Mode  input  1  0 = copy, 1 = fill; latched with Start
- SrcAddr  input  A  copy source base; latched with Start
- DstAddr  input  A  destination base; latched with Start
- Length  input  A+1  byte count, 0..2**A; latched with Start
- FillValue  input  W  fill byte; latched with Start
- Abort  input  1  stop the current operation; sampled in READ/WRITE
- Busy  output  1  high in READ or WRITE
- Done  output  1  one-cycle pulse at completion; not raised on abort
- MemAddress  output  A  address to the memory
- MemWriteEn  output  1  memory write strobe
- MemDataOut  output  W  write data to the memory
- MemDataIn  input  W  combinational read data from the memory

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: src, dst, remaining (A+1 bits), mode, fill, rdbuf.
- IDLE:
  - On Start: latch the parameters.
  - Length==0 → DONE.
  - Otherwise mode=copy → READ; mode=fill → WRITE.
- READ (copy only):
  - Drive MemAddress=src, MemWriteEn=0.
  - At posedge: rdbuf ← MemDataIn, then → WRITE.
- WRITE:
  - Drive MemAddress=dst, MemWriteEn=1.
  - MemDataOut = rdbuf for copy, fill for fill.
  - At posedge: dst++, remaining--. For copy, also src++.
  - If remaining was 1 → DONE. Otherwise copy → READ, fill → WRITE.
- DONE: Done=1 for exactly one cycle, then → IDLE.
- Address arithmetic is modulo 2**A. Incrementing from 2**A-1 wraps to 0, with no error.
- Length=2**A is legal and covers the full memory.
- Overlapping copy regions are processed in strict ascending byte order. If dst>src and the regions overlap, already-written bytes are re-read. This is defined behaviour, not an error.
- Abort:
  - If high in READ or WRITE, go → IDLE at that posedge.
  - Abort has priority over the WRITE-state enable: MemWriteEn is forced to 0 in that cycle.
  - Done is not raised. Bytes already written stay written.
- Start is ignored in READ, WRITE and DONE. A new request is accepted in the first IDLE cycle after DONE.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, MemAddress=0, MemWriteEn=0, MemDataOut=0, and all internal registers 0.
- Reset mid-operation: return to IDLE on the next posedge with no further writes and no Done pulse.
- In IDLE and DONE: MemAddress=0, MemWriteEn=0, MemDataOut=0.
- All outputs are decoded combinationally from registered state. There is no combinational path from Start to the memory outputs.
- Take the Start edge as cycle 0. The first memory access is in cycle 1.
- Copy of N bytes: READ/WRITE alternate over cycles 1..2N, with Done in cycle 2N+1.
- Fill of N bytes: WRITE in cycles 1..N, with Done in cycle N+1.
- Length 0: Done in cycle 1. No memory access occurs.
- Earliest next accepted Start: the cycle after Done.

## Test plan
- Copy, basic:
  - Stimulus: preload mem[0x10..0x12]=AA,BB,CC. Start copy with Src=0x10, Dst=0x40, Len=3.
  - Required: MemWriteEn high only in cycles 2, 4 and 6. mem[0x40..0x42]=AA,BB,CC. Done only in cycle 7. Busy high in cycles 1..6.
- Fill:
  - Stimulus: Start fill with Dst=0x20, Len=4, FillValue=5A.
  - Required: writes in cycles 1..4 to 0x20..0x23, all 5A. Done in cycle 5. mem[0x24] unchanged.
- Wrap and zero length:
  - Stimulus: fill with Dst=0xFE, Len=3, value 77.
  - Required: mem[0xFE], mem[0xFF] and mem[0x00] are 77; mem[0x01] unchanged.
  - Stimulus: Len=0.
  - Required: Done in cycle 1, MemWriteEn never high.
- Overlap:
  - Stimulus: mem[0x00..0x03]=01,02,03,04. Copy with Src=0x00, Dst=0x01, Len=3.
  - Required: mem[0x00..0x03]=01,01,01,01.
- Abort and Reset:
  - Stimulus: copy Len=8, raise Abort in the cycle of the 3rd WRITE (cycle 6).
  - Required: exactly 2 bytes written, MemWriteEn=0 in cycle 6, IDLE in cycle 7, no Done.
  - Stimulus: repeat with Reset asserted instead of Abort.
  - Required: the same result, and all outputs 0 afterwards.
- Start while busy:
  - Stimulus: pulse Start with different parameters during a running fill.
  - Required: the running operation completes unchanged. A new Start in the cycle after Done is accepted.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover: bus-master engine that copies or fills a block of the
// single-port data memory (shared address, combinational read, write on
// the clock edge). Copy costs two cycles per byte (read, then write); fill
// costs one cycle per byte.
module mem_block_mover #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic           Mode,
    input  logic [A-1:0]   SrcAddr,
    input  logic [A-1:0]   DstAddr,
    input  logic [A:0]     Length,
    input  logic [W-1:0]   FillValue,
    input  logic           Abort,
    output logic           Busy,
    output logic           Done,
    output logic [A-1:0]   MemAddress,
    output logic           MemWriteEn,
    output logic [W-1:0]   MemDataOut,
    input  logic [W-1:0]   MemDataIn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [A-1:0]   src;
    logic [A-1:0]   dst;
    logic [A:0]     remaining;
    logic           mode;
    logic [W-1:0]   fill;
    logic [W-1:0]   rdbuf;

    // Sequencer: latch the request in IDLE, then walk the block one byte at a time
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            mode      <= 1'b0;
            fill      <= '0;
            rdbuf     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src       <= SrcAddr;
                        dst       <= DstAddr;
                        remaining <= Length;
                        mode      <= Mode;
                        fill      <= FillValue;
                        if (Length == '0)
                            state <= DONE;
                        else if (Mode)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (Abort) begin
                        state <= IDLE;
                    end else begin
                        rdbuf <= MemDataIn;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (Abort) begin
                        state <= IDLE;
                    end else begin
                        dst       <= dst + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (!mode)
                            src <= src + 1'b1;
                        if (remaining == {{A{1'b0}}, 1'b1})
                            state <= DONE;
                        else if (mode)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-port decode from the registered state; Abort and Reset suppress
    // the write strobe in the cycle they are seen so nothing further lands
    always_comb begin
        Busy       = 1'b0;
        Done       = 1'b0;
        MemAddress = '0;
        MemWriteEn = 1'b0;
        MemDataOut = '0;
        case (state)
            READ: begin
                Busy       = 1'b1;
                MemAddress = src;
            end
            WRITE: begin
                Busy       = 1'b1;
                MemAddress = dst;
                MemWriteEn = !Abort && !Reset;
                MemDataOut = mode ? fill : rdbuf;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural single-port memory.
module tb_mem_block_mover;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Mode;
    logic [7:0]  SrcAddr;
    logic [7:0]  DstAddr;
    logic [8:0]  Length;
    logic [7:0]  FillValue;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic [7:0]  MemAddress;
    logic        MemWriteEn;
    logic [7:0]  MemDataOut;
    logic [7:0]  MemDataIn;

    logic [7:0]  mem [256];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [7:0]  tb_data;

    int compared;
    int mismatched;

    logic [31:0] we_m;
    logic [31:0] busy_m;
    logic [31:0] done_m;
    logic [31:0] last_out;

    mem_block_mover #(.W(8), .A(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
        .FillValue  (FillValue),
        .Abort      (Abort),
        .Busy       (Busy),
        .Done       (Done),
        .MemAddress (MemAddress),
        .MemWriteEn (MemWriteEn),
        .MemDataOut (MemDataOut),
        .MemDataIn  (MemDataIn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single-port memory: DUT write has priority; bench backdoor for preloads
    always @(posedge Clk) begin
        if (MemWriteEn)
            mem[MemAddress] <= MemDataOut;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
    end

    assign MemDataIn = mem[MemAddress];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tick();
        tb_we   = 1'b0;
    endtask

    // Issue one request and record per-cycle strobes (bit c = cycle c after the Start edge).
    // ab/rs: cycle in which Abort/Reset is held; bs: cycle with a conflicting Start pulse.
    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [8:0] len, input logic [7:0] f, input int n,
                       input int ab, input int rs, input int bs);
        Start     = 1'b1;
        Mode      = m;
        SrcAddr   = s;
        DstAddr   = d;
        Length    = len;
        FillValue = f;
        we_m      = '0;
        busy_m    = '0;
        done_m    = '0;
        for (int c = 1; c <= n; c++) begin
            tick();
            Start = (c == bs);
            if (c == bs) begin
                Mode      = 1'b0;
                SrcAddr   = 8'h10;
                DstAddr   = 8'h80;
                Length    = 9'd1;
                FillValue = 8'h99;
            end
            Abort = (c == ab);
            Reset = (c == rs);
            #1;
            we_m[c]   = MemWriteEn;
            busy_m[c] = Busy;
            done_m[c] = Done;
            last_out  = {13'd0, Busy, Done, MemWriteEn, MemAddress, MemDataOut};
        end
        Start = 1'b0;
        Abort = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Reset      = 1'b1;
        Start      = 1'b0;
        Mode       = 1'b0;
        SrcAddr    = '0;
        DstAddr    = '0;
        Length     = '0;
        FillValue  = '0;
        Abort      = 1'b0;
        tb_we      = 1'b0;
        tb_addr    = '0;
        tb_data    = '0;

        tick();
        tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_we", {31'd0, MemWriteEn}, 32'd0);
        chk("rst_addr", {24'd0, MemAddress}, 32'd0);
        chk("rst_dout", {24'd0, MemDataOut}, 32'd0);
        Reset = 1'b0;

        poke(8'h10, 8'hAA);
        poke(8'h11, 8'hBB);
        poke(8'h12, 8'hCC);
        poke(8'h24, 8'h11);
        poke(8'h01, 8'h22);
        poke(8'h80, 8'h33);
        poke(8'h62, 8'hEE);
        poke(8'h72, 8'hEE);

        // Basic copy 0x10 -> 0x40, 3 bytes
        run(1'b0, 8'h10, 8'h40, 9'd3, 8'h00, 8, 0, 0, 0);
        chk("copy_we", we_m, 32'h54);
        chk("copy_busy", busy_m, 32'h7E);
        chk("copy_done", done_m, 32'h80);
        chk("copy_m40", {24'd0, mem[8'h40]}, 32'hAA);
        chk("copy_m41", {24'd0, mem[8'h41]}, 32'hBB);
        chk("copy_m42", {24'd0, mem[8'h42]}, 32'hCC);
        tick();

        // Fill 0x20..0x23 with 5A; conflicting Start pulse in cycle 2 is ignored
        run(1'b1, 8'h00, 8'h20, 9'd4, 8'h5A, 6, 0, 0, 2);
        chk("fill_we", we_m, 32'h1E);
        chk("fill_busy", busy_m, 32'h1E);
        chk("fill_done", done_m, 32'h20);
        chk("fill_m20", {24'd0, mem[8'h20]}, 32'h5A);
        chk("fill_m21", {24'd0, mem[8'h21]}, 32'h5A);
        chk("fill_m22", {24'd0, mem[8'h22]}, 32'h5A);
        chk("fill_m23", {24'd0, mem[8'h23]}, 32'h5A);
        chk("fill_m24", {24'd0, mem[8'h24]}, 32'h11);
        chk("fill_m80", {24'd0, mem[8'h80]}, 32'h33);

        // Start in the cycle right after Done: wrapping fill at 0xFE
        run(1'b1, 8'h00, 8'hFE, 9'd3, 8'h77, 5, 0, 0, 0);
        chk("wrap_we", we_m, 32'h0E);
        chk("wrap_done", done_m, 32'h10);
        chk("wrap_mFE", {24'd0, mem[8'hFE]}, 32'h77);
        chk("wrap_mFF", {24'd0, mem[8'hFF]}, 32'h77);
        chk("wrap_m00", {24'd0, mem[8'h00]}, 32'h77);
        chk("wrap_m01", {24'd0, mem[8'h01]}, 32'h22);
        tick();

        // Zero length
        run(1'b0, 8'h10, 8'h50, 9'd0, 8'h00, 3, 0, 0, 0);
        chk("len0_we", we_m, 32'h0);
        chk("len0_busy", busy_m, 32'h0);
        chk("len0_done", done_m, 32'h02);
        tick();

        // Overlapping ascending copy 0x00 -> 0x01
        poke(8'h00, 8'h01);
        poke(8'h01, 8'h02);
        poke(8'h02, 8'h03);
        poke(8'h03, 8'h04);
        run(1'b0, 8'h00, 8'h01, 9'd3, 8'h00, 8, 0, 0, 0);
        chk("ovl_m00", {24'd0, mem[8'h00]}, 32'h01);
        chk("ovl_m01", {24'd0, mem[8'h01]}, 32'h01);
        chk("ovl_m02", {24'd0, mem[8'h02]}, 32'h01);
        chk("ovl_m03", {24'd0, mem[8'h03]}, 32'h01);
        tick();

        // Abort during the 3rd write (cycle 6)
        run(1'b0, 8'h10, 8'h60, 9'd8, 8'h00, 8, 6, 0, 0);
        chk("abort_we", we_m, 32'h14);
        chk("abort_busy", busy_m, 32'h7E);
        chk("abort_done", done_m, 32'h0);
        chk("abort_m60", {24'd0, mem[8'h60]}, 32'hAA);
        chk("abort_m61", {24'd0, mem[8'h61]}, 32'hBB);
        chk("abort_m62", {24'd0, mem[8'h62]}, 32'hEE);
        tick();

        // Reset during the 3rd write (cycle 6)
        run(1'b0, 8'h10, 8'h70, 9'd8, 8'h00, 8, 0, 6, 0);
        chk("reset_we", we_m, 32'h14);
        chk("reset_busy", busy_m, 32'h7E);
        chk("reset_done", done_m, 32'h0);
        chk("reset_m70", {24'd0, mem[8'h70]}, 32'hAA);
        chk("reset_m71", {24'd0, mem[8'h71]}, 32'hBB);
        chk("reset_m72", {24'd0, mem[8'h72]}, 32'hEE);
        chk("reset_outs", last_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
